// File: rtl/neuron_sched_pkg.sv
// Shared types and constants for the neuron time-step scheduler.
package neuron_sched_pkg;

  localparam int STEP_CNT_W = 16;

  typedef enum logic [1:0] {
    OP_NOP       = 2'd0,
    OP_INTEGRATE = 2'd1,
    OP_FIRE      = 2'd2
  } core_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INTEGRATE,
    ST_FIRE,
    ST_DONE
  } sched_state_t;

endpackage

// File: rtl/neuron_step_scheduler_if.sv
// Spike-in and core-op handshakes of the scheduler.
// The master modport is the scheduler's view; slave is the surrounding logic.
interface neuron_step_scheduler_if #(
  parameter int AXON_W = 8,
  parameter int IDX_W  = 8
);
  import neuron_sched_pkg::*;

  logic              spike_valid_i;
  logic              spike_ready_o;
  logic [AXON_W-1:0] spike_axon_i;
  logic              core_valid_o;
  logic              core_ready_i;
  core_op_t          core_op_o;
  logic [IDX_W-1:0]  core_idx_o;

  modport master (
    input  spike_valid_i, spike_axon_i, core_ready_i,
    output spike_ready_o, core_valid_o, core_op_o, core_idx_o
  );

  modport slave (
    output spike_valid_i, spike_axon_i, core_ready_i,
    input  spike_ready_o, core_valid_o, core_op_o, core_idx_o
  );
endinterface

// File: rtl/neuron_spike_fifo.sv
// Synchronous show-ahead FIFO holding pending spike axon IDs.
module neuron_spike_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  // Head is read straight from the array so it is valid the cycle an entry lands.
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push_ok && !pop_ok)      count_reg <= count_reg + CNT_W'(1);
      else if (pop_ok && !push_ok) count_reg <= count_reg - CNT_W'(1);
    end
  end
endmodule

// File: rtl/neuron_step_scheduler.sv
// Time-step controller: buffers spikes, then runs integrate and fire sweeps on tick.
// Optional build macro SCHED_STALL_CNT_EN enables the core back-pressure counter.
module neuron_step_scheduler
  import neuron_sched_pkg::*;
#(
  parameter int NUM_AXONS   = 256,
  parameter int NUM_NEURONS = 256,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  neuron_step_scheduler_if.master sched_if,
  input  logic                  tick_i,
  input  logic                  clr_status_i,
  output logic                  busy_o,
  output logic                  step_done_o,
  output logic [STEP_CNT_W-1:0] step_count_o,
  output logic                  tick_miss_o,
  output logic [15:0]           stall_cnt_o
);
  localparam int AXON_W   = $clog2(NUM_AXONS);
  localparam int NEURON_W = $clog2(NUM_NEURONS);
  localparam int IDX_W    = (AXON_W > NEURON_W) ? AXON_W : NEURON_W;
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [NEURON_W-1:0] LAST_NEURON = NEURON_W'(NUM_NEURONS - 1);

  sched_state_t              state_reg;
  logic [CNT_W-1:0]          snap_reg;
  logic [NEURON_W-1:0]       nidx_reg;
  logic                      core_valid_reg;
  core_op_t                  core_op_reg;
  logic                      step_done_reg;
  logic [STEP_CNT_W-1:0]     step_count_reg;
  logic                      tick_miss_reg;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic [AXON_W-1:0]         fifo_head;
  logic                      handshake;
  logic [IDX_W-1:0]          core_idx_next;

  assign handshake = core_valid_reg && sched_if.core_ready_i;
  assign fifo_push = sched_if.spike_valid_i && !fifo_full;
  assign fifo_pop  = (state_reg == ST_INTEGRATE) && handshake;

  neuron_spike_fifo #(.WIDTH(AXON_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (sched_if.spike_axon_i),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // Head and nidx only move on a handshake, so the index holds through stalls.
  always_comb begin
    core_idx_next = '0;
    if (state_reg == ST_INTEGRATE)  core_idx_next = IDX_W'(fifo_head);
    else if (state_reg == ST_FIRE)  core_idx_next = IDX_W'(nidx_reg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      snap_reg       <= '0;
      nidx_reg       <= '0;
      core_valid_reg <= 1'b0;
      core_op_reg    <= OP_NOP;
      step_done_reg  <= 1'b0;
      step_count_reg <= '0;
      tick_miss_reg  <= 1'b0;
    end else begin
      step_done_reg <= 1'b0;
      if (tick_i && state_reg != ST_IDLE) tick_miss_reg <= 1'b1;
      else if (clr_status_i)              tick_miss_reg <= 1'b0;

      unique case (state_reg)
        ST_IDLE: if (tick_i) begin
          // Pre-push occupancy: a spike arriving with the tick waits for the next step.
          snap_reg       <= fifo_count;
          nidx_reg       <= '0;
          core_valid_reg <= 1'b1;
          if (!fifo_empty) begin
            state_reg   <= ST_INTEGRATE;
            core_op_reg <= OP_INTEGRATE;
          end else begin
            state_reg   <= ST_FIRE;
            core_op_reg <= OP_FIRE;
          end
        end
        ST_INTEGRATE: if (handshake) begin
          snap_reg <= snap_reg - CNT_W'(1);
          if (snap_reg == CNT_W'(1)) begin
            state_reg   <= ST_FIRE;
            core_op_reg <= OP_FIRE;
            nidx_reg    <= '0;
          end
        end
        ST_FIRE: if (handshake) begin
          if (nidx_reg == LAST_NEURON) begin
            state_reg      <= ST_DONE;
            core_valid_reg <= 1'b0;
            core_op_reg    <= OP_NOP;
            step_done_reg  <= 1'b1;
            step_count_reg <= step_count_reg + STEP_CNT_W'(1);
          end else begin
            nidx_reg <= nidx_reg + NEURON_W'(1);
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign sched_if.spike_ready_o = !fifo_full;
  assign sched_if.core_valid_o  = core_valid_reg;
  assign sched_if.core_op_o     = core_op_reg;
  assign sched_if.core_idx_o    = core_idx_next;
  assign busy_o                 = (state_reg != ST_IDLE);
  assign step_done_o            = step_done_reg;
  assign step_count_o           = step_count_reg;
  assign tick_miss_o            = tick_miss_reg;

`ifdef SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr_status_i)
      stall_cnt_reg <= '0;
    else if (core_valid_reg && !sched_if.core_ready_i && stall_cnt_reg != 16'hFFFF)
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
  end

  assign stall_cnt_o = stall_cnt_reg;
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_neuron_step_scheduler.sv
// Directed bench: table of full time steps plus FIFO-full, missed-tick and mid-step reset sequences.
module tb_neuron_step_scheduler;
  import neuron_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_i;
  logic        clr_status_i;
  logic        busy_o;
  logic        step_done_o;
  logic [15:0] step_count_o;
  logic        tick_miss_o;
  logic [15:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;
  int exp_steps = 0;

  neuron_step_scheduler_if #(.AXON_W(8), .IDX_W(8)) bus ();

  neuron_step_scheduler #(.NUM_AXONS(256), .NUM_NEURONS(256), .FIFO_DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .sched_if     (bus),
    .tick_i       (tick_i),
    .clr_status_i (clr_status_i),
    .busy_o       (busy_o),
    .step_done_o  (step_done_o),
    .step_count_o (step_count_o),
    .tick_miss_o  (tick_miss_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    int               nint;
    logic [3:0][7:0]  ids;
    bit               slow;
    int               exp_done;
    int               exp_stall;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_spikes(input int ids[16], input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("push_rdy%0d", i), bus.spike_ready_o, 1);
      bus.spike_valid_i = 1'b1;
      bus.spike_axon_i  = ids[i][7:0];
      cyc();
    end
    bus.spike_valid_i = 1'b0;
  endtask

  // Runs one step from tick to done and checks op order, latency, stalls and status.
  task automatic run_step(input string name, input int nint, input int ids[16], input bit slow,
                          input int exp_done, input int exp_stall, input int offer_axon,
                          input int inject_at, input bit exp_miss,
                          output logic rdy1, output logic rdy2);
    int       c, p, errs, done_at, eop, eidx;
    logic     prev_stall;
    logic [1:0] prev_op;
    logic [7:0] prev_idx;
    rdy1 = 1'bx;
    rdy2 = 1'bx;
    clr_status_i = 1'b1;
    cyc();
    clr_status_i = 1'b0;
    chk({name, "/miss_clr"}, tick_miss_o, 0);
    tick_i = 1'b1;
    if (offer_axon >= 0) begin
      bus.spike_valid_i = 1'b1;
      bus.spike_axon_i  = offer_axon[7:0];
    end
    bus.core_ready_i = slow ? 1'b0 : 1'b1;
    cyc();
    tick_i = 1'b0;
    bus.spike_valid_i = 1'b0;
    c = 1; p = 0; errs = 0; done_at = -1; prev_stall = 1'b0;
    prev_op = 2'd0; prev_idx = 8'd0;
    while (c < 2000 && done_at < 0) begin
      if (c == 1) rdy1 = bus.spike_ready_o;
      if (c == 2) rdy2 = bus.spike_ready_o;
      if (step_done_o) done_at = c;
      bus.core_ready_i  = slow ? (c % 3 == 0) : 1'b1;
      tick_i            = (c == inject_at);
      clr_status_i      = (c == inject_at);
      bus.spike_valid_i = (c == inject_at);
      bus.spike_axon_i  = 8'd42;
      if (bus.core_valid_o) begin
        if (prev_stall && (bus.core_op_o !== prev_op || bus.core_idx_o !== prev_idx)) errs++;
        if (bus.core_ready_i) begin
          eop  = (p < nint) ? 1 : 2;
          eidx = (p < nint) ? ids[p] : p - nint;
          if (bus.core_op_o !== 2'(eop) || bus.core_idx_o !== 8'(eidx)) errs++;
          p++;
        end
      end
      prev_stall = bus.core_valid_o && !bus.core_ready_i;
      prev_op    = bus.core_op_o;
      prev_idx   = bus.core_idx_o;
      cyc();
      c++;
    end
    tick_i = 1'b0; clr_status_i = 1'b0; bus.spike_valid_i = 1'b0; bus.core_ready_i = 1'b1;
    exp_steps++;
    $display("step %s: ops=%0d done_at=%0d count=%0d", name, p, done_at, step_count_o);
    chk({name, "/op_errs"}, errs, 0);
    chk({name, "/op_total"}, p, nint + 256);
    chk({name, "/done_at"}, done_at, exp_done);
    chk({name, "/done_pulse"}, step_done_o, 0);
    chk({name, "/busy"}, busy_o, 0);
    chk({name, "/count"}, step_count_o, exp_steps);
    chk({name, "/miss"}, tick_miss_o, exp_miss);
`ifdef SCHED_STALL_CNT_EN
    chk({name, "/stall"}, stall_cnt_o, exp_stall);
`else
    chk({name, "/stall"}, stall_cnt_o, 0);
`endif
  endtask

  vec_t vecs[4];
  int   ids[16];
  logic r1, r2;
  int   pulses;

  initial begin
    vecs[0] = '{"empty",  0, {8'd0, 8'd0,   8'd0, 8'd0},   1'b0, 257, 0};
    vecs[1] = '{"integ3", 3, {8'd0, 8'd200, 8'd9, 8'd5},   1'b0, 260, 0};
    vecs[2] = '{"slow1",  1, {8'd0, 8'd0,   8'd0, 8'd255}, 1'b1, 772, 514};
    vecs[3] = '{"integ4", 4, {8'd3, 8'd2,   8'd1, 8'd0},   1'b0, 261, 0};

    rst = 1'b1; tick_i = 1'b0; clr_status_i = 1'b0;
    bus.spike_valid_i = 1'b0; bus.spike_axon_i = 8'd0; bus.core_ready_i = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst/spike_ready", bus.spike_ready_o, 1);
    chk("rst/core_valid", bus.core_valid_o, 0);
    chk("rst/core_op", bus.core_op_o, 0);
    chk("rst/core_idx", bus.core_idx_o, 0);
    chk("rst/busy", busy_o, 0);
    chk("rst/step_done", step_done_o, 0);
    chk("rst/step_count", step_count_o, 0);
    chk("rst/tick_miss", tick_miss_o, 0);
    chk("rst/stall_cnt", stall_cnt_o, 0);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 16; i++) ids[i] = (i < 4) ? int'(vecs[v].ids[i]) : 0;
      push_spikes(ids, vecs[v].nint);
      run_step(vecs[v].name, vecs[v].nint, ids, vecs[v].slow, vecs[v].exp_done,
               vecs[v].exp_stall, -1, -1, 1'b0, r1, r2);
    end

    // Fill the FIFO, then offer a 17th spike together with the tick.
    for (int i = 0; i < 16; i++) ids[i] = 100 + i;
    push_spikes(ids, 16);
    chk("full/spike_ready", bus.spike_ready_o, 0);
    run_step("full16", 16, ids, 1'b0, 273, 0, 77, -1, 1'b0, r1, r2);
    chk("full/ready_before_pop", r1, 0);
    chk("full/ready_after_pop", r2, 1);
    run_step("after_full", 0, ids, 1'b0, 257, 0, -1, -1, 1'b0, r1, r2);

    // Extra tick (with a same-cycle clear) and a spike during FIRE.
    run_step("miss", 0, ids, 1'b0, 257, 0, -1, 10, 1'b1, r1, r2);
    ids[0] = 42;
    run_step("next42", 1, ids, 1'b0, 258, 0, -1, -1, 1'b0, r1, r2);

    // Reset in the middle of an integrate phase.
    ids[0] = 7; ids[1] = 8; ids[2] = 9;
    push_spikes(ids, 3);
    bus.core_ready_i = 1'b0;
    tick_i = 1'b1;
    cyc();
    tick_i = 1'b0;
    chk("mid/valid", bus.core_valid_o, 1);
    chk("mid/op", bus.core_op_o, 1);
    chk("mid/idx", bus.core_idx_o, 7);
    cyc();
    chk("mid/idx_hold", bus.core_idx_o, 7);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.core_ready_i = 1'b1;
    $display("reset mid-integrate: valid=%0d busy=%0d count=%0d", bus.core_valid_o, busy_o, step_count_o);
    chk("rstmid/valid", bus.core_valid_o, 0);
    chk("rstmid/busy", busy_o, 0);
    chk("rstmid/count", step_count_o, 0);
    chk("rstmid/op", bus.core_op_o, 0);
    chk("rstmid/spike_ready", bus.spike_ready_o, 1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (step_done_o) pulses++;
      cyc();
    end
    chk("rstmid/no_done", pulses, 0);
    exp_steps = 0;
    run_step("after_rst", 0, ids, 1'b0, 257, 0, -1, -1, 1'b0, r1, r2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/neuron_step_scheduler.md
Name: neuron_step_scheduler

Overview:
- Time-step controller in front of neuron_core. Buffers incoming spike events (axon IDs) and, on each tick, sequences the core through an integrate phase and then a fire phase.
- Integrate phase: one op per buffered spike. Fire phase: one leak/threshold op per neuron.
- Sits between the spike source (Wishbone/LA-driven spike injector) and neuron_core's operation port. Exports step status for firmware polling.

Parameters:
- NUM_AXONS, 256, number of axon inputs; AXON_W = $clog2(NUM_AXONS)
- NUM_NEURONS, 256, neurons swept in fire phase; NEURON_W = $clog2(NUM_NEURONS)
- FIFO_DEPTH, 16, spike FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- spike_valid_i  in  1  spike event offered
- spike_ready_o  out  1  FIFO not full
- spike_axon_i  in  AXON_W  axon ID of spike
- tick_i  in  1  one-cycle pulse: start a time step
- clr_status_i  in  1  clears tick_miss_o
- core_valid_o  out  1  op presented to neuron_core
- core_ready_i  in  1  neuron_core accepts op
- core_op_o  out  2  0=NOP, 1=INTEGRATE, 2=FIRE
- core_idx_o  out  max(AXON_W,NEURON_W)  axon ID (INTEGRATE) or neuron index (FIRE)
- busy_o  out  1  FSM not IDLE
- step_done_o  out  1  one-cycle pulse at end of step
- step_count_o  out  16  completed steps, wraps at 0xFFFF->0
- tick_miss_o  out  1  sticky: a tick arrived while busy
- stall_cnt_o  out  16  see Optional Feature

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high. All state is registered.
- Reset values: FSM=IDLE, FIFO empty, core_valid_o=0, core_op_o=0, core_idx_o=0, busy_o=0, step_done_o=0, step_count_o=0, tick_miss_o=0, stall_cnt_o=0. spike_ready_o=1 from the first post-reset cycle.
- Reset mid-step: abandons the step and flushes the FIFO. No step_done_o, no count increment.
- FIFO push: on spike_valid_i && spike_ready_o. spike_ready_o = !full.
- FIFO pop: on the core handshake in INTEGRATE.
- Push and pop in the same cycle: occupancy unchanged.
- FSM states: IDLE, INTEGRATE, FIRE, DONE.
- IDLE, on tick_i:
  - snap <= current FIFO occupancy (pre-push value; a spike pushed in the tick cycle belongs to the next step).
  - Next state is INTEGRATE if snap>0, else FIRE.
- INTEGRATE:
  - core_valid_o=1, core_op_o=1, core_idx_o = FIFO head.
  - On core_valid_o && core_ready_i: pop, snap--.
  - When snap reaches 0 on that handshake, go to FIRE with nidx=0.
  - Spikes arriving during the step stay queued.
- FIRE:
  - core_valid_o=1, core_op_o=2, core_idx_o = nidx.
  - On handshake: nidx++. A handshake at nidx=NUM_NEURONS-1 goes to DONE.
- DONE (1 cycle): core_valid_o=0, step_done_o=1, step_count_o++, then IDLE.
- Handshake hold: while core_valid_o && !core_ready_i, core_op_o and core_idx_o are held stable. core_valid_o is never dropped before its handshake.
- Outside INTEGRATE/FIRE: core_op_o=0, core_idx_o=0.
- busy_o=1 in INTEGRATE, FIRE and DONE.
- tick_miss_o:
  - Set by tick_i in any non-IDLE state; that tick is otherwise ignored.
  - Cleared by clr_status_i. If set and clear happen in the same cycle, set wins.
- Latency with core_ready_i=1 and k snapped spikes: tick sampled in cycle T, first op in T+1, step_done_o in T+1+k+NUM_NEURONS.

Optional Feature:
- Macro: SCHED_STALL_CNT_EN.
- Defined: stall_cnt_o counts cycles with core_valid_o && !core_ready_i. Saturates at 0xFFFF, clears on rst or clr_status_i.
- Undefined: the counter logic is absent and stall_cnt_o is tied to 0.

Decomposition:
- Package neuron_sched_pkg holds:
  - core_op_t enum (OP_NOP, OP_INTEGRATE, OP_FIRE)
  - sched_state_t enum
  - STEP_CNT_W=16
- Sub-module: neuron_spike_fifo, a synchronous FIFO. It has push/pop/full/empty/count/head ports, parameterised on width and depth.

Test Plan:
- Reset, empty FIFO, core_ready_i=1, tick at T:
  - FIRE ops idx 0..255 in cycles T+1..T+256.
  - step_done_o at T+257.
  - step_count_o=1.
- Push axons 5, 9, 200, then tick:
  - INTEGRATE ops idx 5, 9, 200 in order, then 256 FIRE ops.
  - FIFO empty afterwards.
  - step_done_o at T+260.
- Push 16 spikes: spike_ready_o=0 after the 16th. Then tick with a simultaneous 17th offer: 17th not accepted, 16 integrates issued, spike_ready_o returns to 1 after the first pop.
- core_ready_i toggling 1-of-3 cycles:
  - core_op_o/core_idx_o stable whenever core_valid_o=1 and core_ready_i=0.
  - With SCHED_STALL_CNT_EN defined, stall_cnt_o equals the number of stall cycles.
- Second tick during FIRE:
  - tick_miss_o=1 and no extra step; step_count_o increments once.
  - clr_status_i clears tick_miss_o.
  - Spike pushed mid-step is integrated in the next step.
- rst asserted mid-INTEGRATE:
  - Next cycle core_valid_o=0, busy_o=0, FIFO empty, step_count_o=0, no step_done_o pulse.
